// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared types and default widths for spram_arbiter
package spram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    RD_WAIT = 2'b10
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spram_arbiter_rr_pick.sv
// rtl/spram_arbiter_rr_pick.sv - combinational winner select (round-robin, or
// fixed lowest-index priority when SPRAM_ARB_FIXED_PRIO_EN is defined)
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
`ifndef SPRAM_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   last_grant,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    idx = '0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) idx = IDX_W'(i);
    end
`else
    begin : rr_search
      logic found;
      int   k;
      found = 1'b0;
      k     = 0;
      // Walk from the requester after the last winner, wrapping around.
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (int'(last_grant) + i) % NUM_REQ;
        if (!found && valid[IDX_W'(k)]) begin
          found = 1'b1;
          idx   = IDX_W'(k);
        end
      end
    end
`endif
    any   = |valid;
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - shares one single-port RAM among NUM_REQ requesters;
// SPRAM_ARB_FIXED_PRIO_EN selects strict priority instead of round-robin
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_next;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               handshake;

  logic [IDX_W-1:0]   cap_idx;
  logic               cap_we;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;

`ifndef SPRAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_grant;
`endif

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .valid     (req_valid),
`ifndef SPRAM_ARB_FIXED_PRIO_EN
    .last_grant(last_grant),
`endif
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  assign handshake = (state == IDLE) && pick_any && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        if (handshake) begin
          req_ready  = pick_grant;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Reset suppresses the RAM access so an interrupted write never lands.
        if (!rst) begin
          ram_en    = 1'b1;
          ram_we    = cap_we;
          ram_addr  = cap_addr;
          ram_wdata = cap_wdata;
        end
        state_next = cap_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_idx   <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifndef SPRAM_ARB_FIXED_PRIO_EN
      last_grant <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state     <= state_next;
      rsp_valid <= '0;
      if (handshake) begin
        cap_idx   <= pick_idx;
        cap_we    <= req_we[pick_idx];
        cap_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        cap_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
`ifndef SPRAM_ARB_FIXED_PRIO_EN
        last_grant <= pick_idx;
`endif
      end
      if (state == RD_WAIT) begin
        rsp_valid <= NUM_REQ'(1) << cap_idx;
        rsp_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - scoreboard bench for spram_arbiter
module tb_spram_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;
  logic            ram_en, ram_we, busy;
  logic [AW-1:0]   ram_addr;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  spram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: read data valid the cycle after the read-issue edge
  logic [DW-1:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] v, input int last);
    int r = 0;
    bit f = 0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
`else
    for (int i = 1; i <= N; i++) begin
      int k = (last + i) % N;
      if (!f && v[k]) begin f = 1; r = k; end
    end
`endif
    return r;
  endfunction

  // Reference model state
  int            m_state = 0;
  int            m_last  = N - 1;
  int            m_g     = 0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wd    = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [N-1:0]  m_rsp_vec = '0;
  logic [DW-1:0] m_mem [16] = '{default: 8'h00};
  logic [DW-1:0] exp_q [$];
  int            grant_log [$];

  logic [N-1:0]  e_ready;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  always @(negedge clk) begin
    if (mon_en) begin
      e_ready = '0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (!rst) begin
        if (m_state == 0 && req_valid != '0) e_ready = N'(1) << m_pick(req_valid, m_last);
        if (m_state == 1) begin e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wd = m_wd; end
      end
      if (m_rsp_vec != '0) begin
        check("rsp_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
      end
      check("req_ready", req_ready, e_ready);
      check("ready_onehot0", $onehot0(req_ready), 1);
      check("ram_en", ram_en, e_en);
      check("ram_we", ram_we, e_we);
      check("ram_addr", ram_addr, e_addr);
      check("ram_wdata", ram_wdata, e_wd);
      check("busy", busy, m_state != 0);
      check("rsp_valid", rsp_valid, m_rsp_vec);
      check("rsp_rdata", rsp_rdata, m_rdata);
      if (rst) begin
        m_state = 0; m_last = N - 1; m_rsp_vec = '0; m_rdata = '0;
        exp_q.delete();
      end else begin
        m_rsp_vec = '0;
        case (m_state)
          0: if (req_valid != '0) begin
            m_g    = m_pick(req_valid, m_last);
            m_last = m_g;
            m_we   = req_we[m_g];
            m_addr = req_addr[m_g*AW +: AW];
            m_wd   = req_wdata[m_g*DW +: DW];
            grant_log.push_back(m_g);
            m_state = 1;
          end
          1: begin
            if (m_we) begin m_mem[m_addr] = m_wd; m_state = 0; end
            else begin exp_q.push_back(m_mem[m_addr]); m_state = 2; end
          end
          default: begin m_rsp_vec = N'(1) << m_g; m_state = 0; end
        endcase
      end
    end
  end

  task automatic drive(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[r]          = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r]       = 1'b1;
  endtask

  task automatic settle(input int budget);
    logic [N-1:0] hs;
    int n = 0;
    while (req_valid != '0 && n < budget) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~hs;
      n++;
    end
    check("settle_timeout", req_valid, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int r, input int budget);
    int n = 0;
    bit got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      got = req_valid[r] & req_ready[r];
      n++;
    end
    check("hs_timeout", got, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic stream(input int n_grants);
    int c = 0, t = 0;
    while (c < n_grants && t < 200) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) c++;
      t++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("stream_timeout", c, n_grants);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // write then read back from requester 0
    drive(0, 1'b1, 4'h3, 8'hA5); settle(20);
    drive(0, 1'b0, 4'h3, 8'h00); settle(20);
    check("t1_rdata", rsp_rdata, 8'hA5);

    // both requesters streaming reads
    drive(0, 1'b1, 4'h1, 8'h11); settle(20);
    drive(1, 1'b1, 4'h2, 8'h22); settle(20);
    grant_log.delete();
    drive(0, 1'b0, 4'h1, 8'h00);
    drive(1, 1'b0, 4'h2, 8'h00);
    stream(4);
    check("t2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
      check("t2_grant_order", grant_log[i], 0);
`else
      check("t2_grant_order", grant_log[i], i % 2);
`endif
    end

    // reset during RD_WAIT discards the response
    drive(1, 1'b0, 4'h2, 8'h00);
    wait_hs(1, 20);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_ram_en", ram_en, 0);
    repeat (4) @(posedge clk);
    #1;

    // simultaneous write(1) and read(0) at 0xF after pointer reset
    grant_log.delete();
    drive(1, 1'b1, 4'hF, 8'h3C);
    drive(0, 1'b0, 4'hF, 8'h00);
    settle(20);
    check("t3_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_first", grant_log[0], 0);
      check("t3_second", grant_log[1], 1);
    end
    check("t3_old_data", rsp_rdata, 8'h00);
    drive(0, 1'b0, 4'hF, 8'h00); settle(20);
    check("t3_new_data", rsp_rdata, 8'h3C);

    // request raised while busy is held and accepted later
    drive(0, 1'b1, 4'h5, 8'h5A);
    wait_hs(0, 20);
    drive(1, 1'b0, 4'h5, 8'h00);
    check("t5_busy", busy, 1);
    check("t5_ready_while_busy", req_ready, 0);
    settle(20);
    check("t5_rdata", rsp_rdata, 8'h5A);

    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Round-robin arbiter that shares one synchronous single-port RAM (16 x 8 by default) between NUM_REQ requesters. Each requester issues read/write commands over a valid/ready handshake. The arbiter serialises the commands onto the RAM port and returns read data with a one-cycle response strobe. It sits between client blocks (DMA, CPU-side register bridge) and the RAM instance.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width

- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  command valid, one bit per requester
- req_ready  out  NUM_REQ  command accepted (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe to the owning requester
- rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the read-issue edge
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, RD_WAIT.
- IDLE, any req_valid high:
  - Winner g is picked combinationally.
  - req_ready[g]=1 in the same cycle; the handshake completes.
  - g, we, addr and wdata are captured.
  - Next state is ISSUE.
- IDLE, no valid: stay in IDLE. All outputs are 0.
- ISSUE:
  - ram_en=1; ram_we, ram_addr and ram_wdata are driven from the captured command.
  - Write → IDLE. The RAM commits at the end of the ISSUE cycle.
  - Read → RD_WAIT.
- RD_WAIT: ram_en=0. At the clock edge, rsp_rdata <= ram_rdata and rsp_valid[g] <= 1. Next state is IDLE.
- rsp_valid is high for exactly one cycle. rsp_rdata holds its value until the next read response.
- Round-robin rule:
  - Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - last_grant updates to g on every handshake.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 wins first.
- Requester rules:
  - Hold req_valid and payload stable until req_ready.
  - Requests raised while busy wait; they are never dropped.
- req_ready is never asserted outside IDLE. At most one bit of req_ready is high.
- Writes never produce rsp_valid.
- ram_addr, ram_we and ram_wdata are 0 whenever ram_en=0.

## Timing
- Reset values: state=IDLE; all outputs, including req_ready and rsp_valid, are 0; last_grant=NUM_REQ-1.
- Read: handshake at T, ram_en at T+1, RD_WAIT at T+2, rsp_valid at T+3. The next handshake is possible at T+3.
- Write: handshake at T, ram_en/ram_we at T+1, next handshake possible at T+2.
- Reset mid-operation:
  - Next cycle is IDLE, with ram_en=0 during the rst cycle.
  - A pending read response is discarded (no rsp_valid).
  - A write in ISSUE while rst=1 is not issued (ram_en forced 0).
- Simultaneous requests: exactly one is granted per IDLE cycle, and the others are served in rotation order. With NUM_REQ requesters continuously valid, each is granted once every NUM_REQ grants.
- Read-after-write at the same address from different requesters returns the new data; ordering is the grant order.

## Configuration
- SPRAM_ARB_FIXED_PRIO_EN
  - Defined: strict priority, lowest index wins. last_grant is not implemented. Higher indices may starve.
  - Undefined (default): round-robin as above.

## Structure
- Package spram_arb_pkg:
  - state typedef: IDLE=2'b00, ISSUE=2'b01, RD_WAIT=2'b10.
  - Default ADDR_W/DATA_W constants.
- Sub-module rr_pick:
  - Combinational winner select from req_valid and last_grant.
  - Outputs a one-hot grant and a binary index.
  - Handles the fixed-priority variant under the macro.

## Test plan
- Reset, then requester 0 writes 0xA5 to addr 0x3; requester 0 then reads addr 0x3 → ram_en/ram_we pulse at T+1; rsp_valid[0] at read T+3 with rsp_rdata=0xA5.
- Both requesters valid continuously, reading addrs 0x1 and 0x2 → grants alternate 0,1,0,1; each rsp_valid goes to the matching requester with correct data; req_ready is never two-hot.
- Requester 1 writes 0x3C to 0xF while requester 0 reads 0xF in the same IDLE cycle (reset pointer) → requester 0 granted first and reads the old value 0x00; a later read returns 0x3C.
- rst asserted during RD_WAIT → no rsp_valid; busy=0 and all outputs 0 the next cycle; a new request is accepted normally afterward.
- req_valid raised while busy and held → accepted in the first IDLE cycle; payload unchanged.
- With SPRAM_ARB_FIXED_PRIO_EN and both requesters continuously valid → requester 0 is granted every time; requester 1 is never granted.
